// File: rtl/id_ex_reg_if.sv
// ----------------------------------------------------------------------------
// id_ex_reg_if
//
// Purpose:
//   Bundles the ID-side inputs and EX-side outputs of the ID/EX pipeline
//   register. Clock and reset stay as plain ports on the register itself.
//
// Signals:
//   stall_i, flush_i, bubble_i        stage control from hazard / branch logic
//   wb_i[1:0], mem_i[2:0], ex_i[3:0]  control bundle from the hazard mux
//   pc_i, rs_data_i, rt_data_i, imm_i 32-bit data captured at end of ID
//   rs_addr_i, rt_addr_i, rd_addr_i   5-bit register numbers
//   *_o                               registered copies presented to EX
//   mem_read_o                        tap of mem_o[1] for load-use detection
//   valid_o                           EX holds a real instruction
//   bubble_cnt_o                      bubble performance counter
//
// Modports:
//   master  side that drives the ID inputs and observes the EX outputs
//   slave   the pipeline register itself
// ----------------------------------------------------------------------------
interface id_ex_reg_if;
    logic        stall_i;
    logic        flush_i;
    logic        bubble_i;
    logic [1:0]  wb_i;
    logic [2:0]  mem_i;
    logic [3:0]  ex_i;
    logic [31:0] pc_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic [31:0] imm_i;
    logic [4:0]  rs_addr_i;
    logic [4:0]  rt_addr_i;
    logic [4:0]  rd_addr_i;

    logic [1:0]  wb_o;
    logic [2:0]  mem_o;
    logic [3:0]  ex_o;
    logic [31:0] pc_o;
    logic [31:0] rs_data_o;
    logic [31:0] rt_data_o;
    logic [31:0] imm_o;
    logic [4:0]  rs_addr_o;
    logic [4:0]  rt_addr_o;
    logic [4:0]  rd_addr_o;
    logic        mem_read_o;
    logic        valid_o;
    logic [15:0] bubble_cnt_o;

    modport master (
        output stall_i, flush_i, bubble_i, wb_i, mem_i, ex_i,
               pc_i, rs_data_i, rt_data_i, imm_i,
               rs_addr_i, rt_addr_i, rd_addr_i,
        input  wb_o, mem_o, ex_o, pc_o, rs_data_o, rt_data_o, imm_o,
               rs_addr_o, rt_addr_o, rd_addr_o, mem_read_o, valid_o,
               bubble_cnt_o
    );

    modport slave (
        input  stall_i, flush_i, bubble_i, wb_i, mem_i, ex_i,
               pc_i, rs_data_i, rt_data_i, imm_i,
               rs_addr_i, rt_addr_i, rd_addr_i,
        output wb_o, mem_o, ex_o, pc_o, rs_data_o, rt_data_o, imm_o,
               rs_addr_o, rt_addr_o, rd_addr_o, mem_read_o, valid_o,
               bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ----------------------------------------------------------------------------
// id_ex_reg
//
// Purpose:
//   ID/EX pipeline register of the five-stage MIPS core. Captures the control
//   bundle, PC+4, register read data, immediate and register numbers at the
//   end of ID and presents them to EX for one cycle. Supports stall (hold),
//   flush (bubble insert) and hazard bubbles.
//
// Ports:
//   clk_i  pipeline clock, rising edge
//   rst_i  asynchronous active-low reset, clears every output
//   bus    id_ex_reg_if.slave, all ID inputs and EX outputs
//
// Edge priority: reset > flush > stall > bubble load > normal load.
//
// Configuration macro:
//   ID_EX_PERF_EN  when defined, bus.bubble_cnt_o is a saturating 16-bit count
//                  of bubbles loaded; otherwise it is tied to zero.
// ----------------------------------------------------------------------------
module id_ex_reg (
    input  logic       clk_i,
    input  logic       rst_i,
    id_ex_reg_if.slave bus
);

    logic [1:0]  r_wb;
    logic [2:0]  r_mem;
    logic [3:0]  r_ex;
    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    logic [4:0]  r_rs_addr;
    logic [4:0]  r_rt_addr;
    logic [4:0]  r_rd_addr;

    // Control fields and valid. A bubble (flush or hazard) always zeroes the
    // control bundle so an invalid slot can never commit downstream.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb    <= 2'b00;
            r_mem   <= 3'b000;
            r_ex    <= 4'b0000;
            r_valid <= 1'b0;
        end else if (bus.flush_i) begin
            r_wb    <= 2'b00;
            r_mem   <= 3'b000;
            r_ex    <= 4'b0000;
            r_valid <= 1'b0;
        end else if (bus.stall_i) begin
            r_wb    <= r_wb;
            r_mem   <= r_mem;
            r_ex    <= r_ex;
            r_valid <= r_valid;
        end else if (bus.bubble_i) begin
            r_wb    <= 2'b00;
            r_mem   <= 3'b000;
            r_ex    <= 4'b0000;
            r_valid <= 1'b0;
        end else begin
            r_wb    <= bus.wb_i;
            r_mem   <= bus.mem_i;
            r_ex    <= bus.ex_i;
            r_valid <= 1'b1;
        end
    end

    // Data and address fields. A flush only squashes control, so the data
    // is left as it was; a hazard bubble still loads data normally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pc      <= 32'h0;
            r_rs_data <= 32'h0;
            r_rt_data <= 32'h0;
            r_imm     <= 32'h0;
            r_rs_addr <= 5'd0;
            r_rt_addr <= 5'd0;
            r_rd_addr <= 5'd0;
        end else if (!bus.flush_i && !bus.stall_i) begin
            r_pc      <= bus.pc_i;
            r_rs_data <= bus.rs_data_i;
            r_rt_data <= bus.rt_data_i;
            r_imm     <= bus.imm_i;
            r_rs_addr <= bus.rs_addr_i;
            r_rt_addr <= bus.rt_addr_i;
            r_rd_addr <= bus.rd_addr_i;
        end
    end

`ifdef ID_EX_PERF_EN
    logic        w_load_bubble;
    logic [15:0] r_bubble_cnt;

    // A bubble is loaded on any flush, or on a hazard bubble that is not
    // held back by a stall.
    assign w_load_bubble = bus.flush_i | (bus.bubble_i & ~bus.stall_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= 16'h0000;
        end else if (w_load_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end
    end

    assign bus.bubble_cnt_o = r_bubble_cnt;
`else
    assign bus.bubble_cnt_o = 16'h0000;
`endif

    assign bus.wb_o       = r_wb;
    assign bus.mem_o      = r_mem;
    assign bus.ex_o       = r_ex;
    assign bus.valid_o    = r_valid;
    assign bus.pc_o       = r_pc;
    assign bus.rs_data_o  = r_rs_data;
    assign bus.rt_data_o  = r_rt_data;
    assign bus.imm_o      = r_imm;
    assign bus.rs_addr_o  = r_rs_addr;
    assign bus.rt_addr_o  = r_rt_addr;
    assign bus.rd_addr_o  = r_rd_addr;
    // MemRead bit of the registered mem bundle, tapped for load-use detection.
    assign bus.mem_read_o = r_mem[1];

endmodule

// File: tb/tb_id_ex_reg.sv
// ----------------------------------------------------------------------------
// tb_id_ex_reg
//
// Self-checking bench for id_ex_reg. A reference model computes the expected
// output state each time stimulus is applied and pushes it into a scoreboard
// queue; after the clock edge the entry is popped and compared against the
// DUT outputs. Define ID_EX_PERF_EN to also exercise the bubble counter.
// ----------------------------------------------------------------------------
module tb_id_ex_reg;

    typedef struct packed {
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  ex;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic        mem_read;
        logic        valid;
        logic [15:0] cnt;
    } out_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    out_t model;
    out_t sb_q[$];

    id_ex_reg_if bus ();

    id_ex_reg dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t observe();
        out_t o;
        o.wb       = bus.wb_o;
        o.mem      = bus.mem_o;
        o.ex       = bus.ex_o;
        o.pc       = bus.pc_o;
        o.rs_data  = bus.rs_data_o;
        o.rt_data  = bus.rt_data_o;
        o.imm      = bus.imm_o;
        o.rs_addr  = bus.rs_addr_o;
        o.rt_addr  = bus.rt_addr_o;
        o.rd_addr  = bus.rd_addr_o;
        o.mem_read = bus.mem_read_o;
        o.valid    = bus.valid_o;
        o.cnt      = bus.bubble_cnt_o;
        return o;
    endfunction

    // Reference behaviour of one rising edge with reset released.
    function automatic out_t model_next(input out_t cur);
        out_t n;
        n = cur;
        if (bus.flush_i) begin
            n.wb = 2'b00; n.mem = 3'b000; n.ex = 4'b0000; n.valid = 1'b0;
        end else if (!bus.stall_i) begin
            n.pc      = bus.pc_i;
            n.rs_data = bus.rs_data_i;
            n.rt_data = bus.rt_data_i;
            n.imm     = bus.imm_i;
            n.rs_addr = bus.rs_addr_i;
            n.rt_addr = bus.rt_addr_i;
            n.rd_addr = bus.rd_addr_i;
            if (bus.bubble_i) begin
                n.wb = 2'b00; n.mem = 3'b000; n.ex = 4'b0000; n.valid = 1'b0;
            end else begin
                n.wb = bus.wb_i; n.mem = bus.mem_i; n.ex = bus.ex_i; n.valid = 1'b1;
            end
        end
        n.mem_read = n.mem[1];
`ifdef ID_EX_PERF_EN
        if ((bus.flush_i || (bus.bubble_i && !bus.stall_i)) && cur.cnt != 16'hFFFF)
            n.cnt = cur.cnt + 16'd1;
`endif
        return n;
    endfunction

    // Apply current inputs across one rising edge; expected result queued.
    task automatic step();
        model = model_next(model);
        sb_q.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic s, input logic f, input logic b);
        bus.stall_i  = s;
        bus.flush_i  = f;
        bus.bubble_i = b;
    endtask

    task automatic set_random_inputs();
        bus.wb_i      = 2'($urandom);
        bus.mem_i     = 3'($urandom);
        bus.ex_i      = 4'($urandom);
        bus.pc_i      = $urandom;
        bus.rs_data_i = $urandom;
        bus.rt_data_i = $urandom;
        bus.imm_i     = $urandom;
        bus.rs_addr_i = 5'($urandom);
        bus.rt_addr_i = 5'($urandom);
        bus.rd_addr_i = 5'($urandom);
    endtask

    task automatic test_reset();
        out_t obs;
        out_t exp;
        // Power-on reset state
        rst_n = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_random_inputs();
        repeat (2) @(posedge clk);
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got %h required 0", obs);
        end
        $display("reset_initial: outputs %h", obs);
        model = '0;
        rst_n = 1'b1;
        // Load nonzero values, then assert reset mid-cycle
        bus.wb_i = 2'b11; bus.mem_i = 3'b111; bus.ex_i = 4'b1111;
        bus.pc_i = 32'hFFFF_FFFC; bus.rs_addr_i = 5'd31;
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_preload: got %h required %h", obs, exp);
        end
        bus.bubble_i = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got %h required 0", obs);
        end
        $display("reset_async: outputs %h", obs);
        model = '0;
        @(posedge clk);
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_held: got %h required 0", obs);
        end
        #2 rst_n = 1'b1;
        bus.bubble_i = 1'b0;
    endtask

    task automatic test_normal_load();
        out_t obs;
        out_t exp;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_random_inputs();
        bus.wb_i = 2'b10; bus.mem_i = 3'b010; bus.ex_i = 4'b1011;
        bus.pc_i = 32'h0000_0040; bus.rt_addr_i = 5'd9;
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL normal_load: got %h required %h", obs, exp);
        end
        n_checks++;
        if (bus.valid_o !== 1'b1 || bus.mem_read_o !== 1'b1 || bus.ex_o !== 4'b1011 ||
            bus.pc_o !== 32'h40 || bus.rt_addr_o !== 5'd9 || bus.wb_o !== 2'b10) begin
            n_fail++;
            $display("FAIL normal_fields: got valid=%b mem_read=%b ex=%b pc=%h rt=%0d wb=%b required 1 1 1011 40 9 10",
                     bus.valid_o, bus.mem_read_o, bus.ex_o, bus.pc_o, bus.rt_addr_o, bus.wb_o);
        end
        $display("normal_load: pc_o=%h valid_o=%b", bus.pc_o, bus.valid_o);
    endtask

    task automatic test_bubble();
        out_t obs;
        out_t exp;
        logic [15:0] cnt_req;
`ifdef ID_EX_PERF_EN
        cnt_req = model.cnt + 16'd1;
`else
        cnt_req = 16'h0;
`endif
        set_ctrl(1'b0, 1'b0, 1'b1);
        bus.ex_i = 4'b1111; bus.wb_i = 2'b11; bus.mem_i = 3'b111;
        bus.rs_data_i = 32'hDEAD_BEEF;
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL bubble: got %h required %h", obs, exp);
        end
        n_checks++;
        if (bus.ex_o !== 4'b0 || bus.wb_o !== 2'b0 || bus.mem_o !== 3'b0 ||
            bus.valid_o !== 1'b0 || bus.rs_data_o !== 32'hDEAD_BEEF || bus.bubble_cnt_o !== cnt_req) begin
            n_fail++;
            $display("FAIL bubble_fields: got ex=%b wb=%b mem=%b valid=%b rs=%h cnt=%h required 0 0 0 0 deadbeef %h",
                     bus.ex_o, bus.wb_o, bus.mem_o, bus.valid_o, bus.rs_data_o, bus.bubble_cnt_o, cnt_req);
        end
        $display("bubble: rs_data_o=%h cnt=%h", bus.rs_data_o, bus.bubble_cnt_o);
    endtask

    task automatic test_stall();
        out_t obs;
        out_t exp;
        logic [15:0] cnt_hold;
        set_ctrl(1'b0, 1'b0, 1'b0);
        bus.pc_i = 32'h100;
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL stall_preload: got %h required %h", obs, exp);
        end
        cnt_hold = model.cnt;
        for (int i = 0; i < 3; i++) begin
            set_ctrl(1'b1, 1'b0, (i == 1));
            set_random_inputs();
            bus.pc_i = 32'h104;
            step();
            exp = sb_q.pop_front();
            obs = observe();
            n_checks++;
            if (obs !== exp || bus.pc_o !== 32'h100 || bus.bubble_cnt_o !== cnt_hold) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got pc=%h cnt=%h state %h required pc=100 cnt=%h state %h",
                         i, bus.pc_o, bus.bubble_cnt_o, obs, cnt_hold, exp);
            end
            $display("stall cycle %0d: pc_o=%h", i, bus.pc_o);
        end
        set_ctrl(1'b0, 1'b0, 1'b0);
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp || bus.pc_o !== 32'h104) begin
            n_fail++;
            $display("FAIL stall_release: got pc=%h state %h required pc=104 state %h", bus.pc_o, obs, exp);
        end
        $display("stall release: pc_o=%h", bus.pc_o);
    endtask

    task automatic test_flush_over_stall();
        out_t obs;
        out_t exp;
        logic [15:0] cnt_req;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_random_inputs();
        bus.wb_i = 2'b10; bus.pc_i = 32'h200;
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp || bus.valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_preload: got %h required %h", obs, exp);
        end
`ifdef ID_EX_PERF_EN
        cnt_req = model.cnt + 16'd1;
`else
        cnt_req = 16'h0;
`endif
        set_ctrl(1'b1, 1'b1, 1'b0);
        set_random_inputs();
        step();
        exp = sb_q.pop_front();
        obs = observe();
        n_checks++;
        if (obs !== exp || bus.pc_o !== 32'h200 || bus.valid_o !== 1'b0 ||
            {bus.wb_o, bus.mem_o, bus.ex_o} !== 9'd0 || bus.bubble_cnt_o !== cnt_req) begin
            n_fail++;
            $display("FAIL flush_over_stall: got pc=%h valid=%b ctrl=%h cnt=%h required pc=200 valid=0 ctrl=0 cnt=%h",
                     bus.pc_o, bus.valid_o, {bus.wb_o, bus.mem_o, bus.ex_o}, bus.bubble_cnt_o, cnt_req);
        end
        $display("flush_over_stall: pc_o=%h valid_o=%b", bus.pc_o, bus.valid_o);
    endtask

    task automatic test_back_to_back();
        out_t obs;
        out_t exp;
        for (int i = 0; i < 40; i++) begin
            set_ctrl(($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            set_random_inputs();
            step();
            exp = sb_q.pop_front();
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL back_to_back%0d: got %h required %h", i, obs, exp);
            end
            n_checks++;
            if (!bus.valid_o && {bus.wb_o, bus.mem_o, bus.ex_o} !== 9'd0) begin
                n_fail++;
                $display("FAIL invalid_ctrl%0d: got ctrl=%h required 0", i, {bus.wb_o, bus.mem_o, bus.ex_o});
            end
            $display("b2b %0d: s=%b f=%b b=%b valid_o=%b pc_o=%h", i,
                     bus.stall_i, bus.flush_i, bus.bubble_i, bus.valid_o, bus.pc_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_t obs;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_random_inputs();
        step();
        void'(sb_q.pop_front());
        set_ctrl(1'b1, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        obs = observe();
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h required 0", obs);
        end
        $display("reset_mid_stall: outputs %h", obs);
        model = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        set_ctrl(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        out_t obs;
        out_t exp;
        int   errs;
        logic [15:0] cnt_req;
        errs = 0;
        set_ctrl(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            step();
            exp = sb_q.pop_front();
            obs = observe();
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL saturation%0d: got %h required %h", i, obs, exp);
            end
        end
`ifdef ID_EX_PERF_EN
        cnt_req = 16'hFFFF;
`else
        cnt_req = 16'h0000;
`endif
        n_checks++;
        if (bus.bubble_cnt_o !== cnt_req) begin
            n_fail++;
            $display("FAIL saturation_final: got cnt=%h required %h", bus.bubble_cnt_o, cnt_req);
        end
        $display("saturation: bubble_cnt_o=%h after 65540 flushes", bus.bubble_cnt_o);
        set_ctrl(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = '0;
        rst_n    = 1'b0;
        set_ctrl(1'b0, 1'b0, 1'b0);
        set_random_inputs();
        test_reset();
        test_normal_load();
        test_bubble();
        test_stall();
        test_flush_over_stall();
        test_back_to_back();
        test_reset_mid_stall();
        test_normal_load();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
